// File: rtl/handshake_pkg.sv
// Shared types and constants for the round-robin handshake arbiter.
// Provides the FSM state enum, grant index width helper and beat counter width.
package handshake_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Wide enough for MAX_BURST up to 255.
    localparam int CNT_W = 8;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Rotating-priority picker: first set request at or above i_ptr, with wrap.
// Ports: i_req (request vector), i_ptr (start index), o_found, o_idx.
module handshake_rr_pick
    import handshake_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/handshake_arb.sv
// Round-robin arbiter sharing one registered valid/ready output among N_REQ
// producers. Ports: clk, rst_n (sync, active-low), req_valid/req_data/
// req_ready per producer, out_valid/out_data/out_ready downstream,
// grant_active/grant_idx status.
module handshake_arb
    import handshake_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int N_REQ     = 4,
    parameter  int MAX_BURST = 4,
    localparam int IDX_W     = idx_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic                   grant_active,
    output logic [IDX_W-1:0]       grant_idx
);

    state_e           r_state;
    state_e           w_next;
    logic [IDX_W-1:0] r_gidx;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_ptr_next;
    logic             w_slot_open;
    logic             w_gvalid;
    logic [WIDTH-1:0] w_gdata;
    logic             w_acc;
    logic             w_release;

    handshake_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_slot_open = !r_out_valid || out_ready;
    assign w_gvalid    = req_valid[r_gidx];
    assign w_gdata     = req_data[r_gidx*WIDTH +: WIDTH];
    assign w_ptr_next  = (r_gidx == IDX_W'(N_REQ-1))
                       ? '0 : r_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // req_ready depends only on state and output slot, never on req_valid.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_acc     = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next = GRANT;
                end
            end
            GRANT: begin
                req_ready[r_gidx] = w_slot_open;
                w_acc     = w_gvalid && w_slot_open;
                w_release = !w_gvalid
                          || (w_acc
                          && r_cnt == CNT_W'(MAX_BURST-1));
                if (w_release) begin
                    w_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gidx      <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_gidx <= w_pick;
                r_cnt  <= '0;
            end
            if (w_acc) begin
                r_out_data  <= w_gdata;
                r_out_valid <= 1'b1;
                r_cnt       <= r_cnt + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Release does not wait for the output stage to drain.
            if (w_release) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign grant_active = (r_state == GRANT);
    assign grant_idx    = r_gidx;

endmodule

// File: tb/tb_handshake_arb.sv
// Directed scoreboard bench for handshake_arb (default params) plus a
// MAX_BURST=1, N_REQ=2 instance checking alternating grants.
module tb_handshake_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        grant_active;
    logic [1:0]  grant_idx;

    logic        rst2_n;
    logic [1:0]  rv2;
    logic [15:0] rd2;
    logic [1:0]  rr2;
    logic        ov2;
    logic [7:0]  od2;
    logic        gact2;
    logic [0:0]  gidx2;

    handshake_arb #(
        .WIDTH     (8),
        .N_REQ     (4),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .grant_active (grant_active),
        .grant_idx    (grant_idx)
    );

    handshake_arb #(
        .WIDTH     (8),
        .N_REQ     (2),
        .MAX_BURST (1)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst2_n),
        .req_valid    (rv2),
        .req_data     (rd2),
        .req_ready    (rr2),
        .out_valid    (ov2),
        .out_data     (od2),
        .out_ready    (1'b1),
        .grant_active (gact2),
        .grant_idx    (gidx2)
    );

    int         passed;
    int         total;
    logic [7:0] exp_q[$];
    int         sent[4];

    logic       s_valid;
    logic       s_gact;
    logic [3:0] s_ready;
    logic [1:0] s_gidx;
    logic [7:0] s_data;

    bit         ph2;
    logic [7:0] exp2;
    int         n2;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h",
                    tag, obs, exp);
    endtask

    task automatic update_data();
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = 8'(16*i + sent[i] % 4);
        end
    endtask

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    // Sample at negedge, then advance producers past the next posedge.
    task automatic tick();
        logic [3:0] acc;
        logic       rs;
        @(negedge clk);
        acc     = req_valid & req_ready;
        rs      = rst_n;
        s_valid = out_valid;
        s_gact  = grant_active;
        s_ready = req_ready;
        s_gidx  = grant_idx;
        s_data  = out_data;
        chk("ready_onehot",
            32'($countones(req_ready) <= 1), 32'd1);
        if (out_valid && out_ready) begin
            chk("beat_expected",
                32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("beat_data", 32'(out_data),
                    32'(exp_q.pop_front()));
            end
        end
        if (ph2 && ov2) begin
            chk("mb1_data", 32'(od2), 32'(exp2));
            exp2 = (exp2 == 8'hA0) ? 8'hB1 : 8'hA0;
            n2++;
        end
        @(posedge clk);
        #1;
        if (rs) begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) sent[i]++;
            end
        end
        update_data();
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        ph2       = 1'b0;
        exp2      = 8'hA0;
        n2        = 0;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_data  = '0;
        update_data();
        rst2_n    = 1'b0;
        rv2       = 2'b11;
        rd2       = {8'hB1, 8'hA0};

        // Reset with all requesters valid
        for (int i = 0; i < 3; i++) tick();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_gact",  32'(s_gact),  32'd0);
        chk("rst_gidx",  32'(s_gidx),  32'd0);
        chk("rst_data",  32'(s_data),  32'd0);

        // Contention: all four valid, full rate output
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) push(8'(16*g + b));
        end
        push(8'h00);
        rst_n = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t >= 2) begin
                chk("bubble_pattern", 32'(s_valid),
                    32'(((t-2) % 5) != 0));
                if (((t-2) % 5) == 1) begin
                    chk("cont_gidx", 32'(s_gidx),
                        32'(((t-2) / 5) % 4));
                end
            end
        end
        req_valid = 4'b0000;
        tick();
        tick();
        chk("cont_gact_off", 32'(s_gact), 32'd0);
        chk("cont_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure on requester 2
        for (int b = 0; b < 4; b++) push(8'(8'h20 + b));
        req_valid = 4'b0100;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        for (int t = 4; t <= 7; t++) begin
            tick();
            chk("bp_valid", 32'(s_valid), 32'd1);
            chk("bp_data",  32'(s_data),  32'h21);
            chk("bp_ready", 32'(s_ready), 32'd0);
            chk("bp_gidx",  32'(s_gidx),  32'd2);
        end
        out_ready = 1'b1;
        tick();
        tick();
        req_valid = 4'b0000;
        tick();
        chk("bp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("bp_sent", 32'(sent[2]), 32'd8);

        // Early release of requester 1, requester 3 wins over 0
        push(8'h10);
        push(8'h11);
        for (int b = 0; b < 4; b++) push(8'(8'h30 + b));
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1011;
        tick();
        tick();
        req_valid = 4'b1001;
        tick();
        chk("er_gidx1", 32'(s_gidx), 32'd1);
        tick();
        chk("er_idle",  32'(s_gact),  32'd0);
        chk("er_ready", 32'(s_ready), 32'd0);
        tick();
        chk("er_gact3", 32'(s_gact),  32'd1);
        chk("er_gidx3", 32'(s_gidx),  32'd3);
        chk("er_rdy3",  32'(s_ready), 32'b1000);
        tick();
        tick();
        tick();
        req_valid = 4'b0000;
        tick();
        chk("er_q_empty", 32'(exp_q.size()), 32'd0);

        // Mid-burst reset during requester 0's third beat
        sent[0] = 0;
        update_data();
        push(8'h00);
        push(8'h01);
        req_valid = 4'b0001;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        chk("mr_valid", 32'(s_valid), 32'd0);
        chk("mr_gact",  32'(s_gact),  32'd0);
        chk("mr_ready", 32'(s_ready), 32'd0);
        chk("mr_data",  32'(s_data),  32'd0);
        chk("mr_sent",  32'(sent[0]), 32'd2);
        rst_n = 1'b1;
        push(8'h02);
        push(8'h03);
        push(8'h00);
        push(8'h01);
        tick();
        tick();
        chk("mr_regrant", 32'(s_gact), 32'd1);
        chk("mr_gidx",    32'(s_gidx), 32'd0);
        tick();
        tick();
        tick();
        chk("mr_burst_on", 32'(s_gact), 32'd1);
        req_valid = 4'b0000;
        tick();
        chk("mr_burst_off", 32'(s_gact), 32'd0);
        tick();
        chk("mr_q_empty", 32'(exp_q.size()), 32'd0);

        // MAX_BURST=1, two requesters always valid
        ph2    = 1'b1;
        rst2_n = 1'b1;
        for (int t = 0; t < 12; t++) tick();
        chk("mb1_beats", 32'(n2), 32'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
